fetch_sequencer: RTL and testbench

Instruction fetch and PC sequencing unit for the single-cycle-issue MIPS core. It requests instruction words from instruction memory, holds the fetched word in an instruction register, and presents the opcode field to the main control decoder. It then consumes the decoder's `branch`/`jump` outputs and the ALU `zero` flag to compute the next PC. A halt opcode (6'b111111) stops fetching permanently until reset.

---
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencing for the single-cycle-issue MIPS core.
// Fetches into an instruction register, issues it, then steps the PC on commit.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        commit,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } stateT;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    stateT       state;
    stateT       nextState;
    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic        loadInstr;
    logic        loadPc;

    logic [31:0] pcPlus4;
    logic [31:0] jumpTarget;
    logic [31:0] branchOffset;
    logic [31:0] branchTarget;
    logic [31:0] pcNext;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        loadInstr = 1'b0;
        loadPc    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                // Request held with no timeout; a halt word parks the unit for good.
                if (imem_valid) begin
                    loadInstr = 1'b1;
                    nextState = (imem_rdata[31:26] == HALT_OPCODE) ? HALT : ISSUE;
                end
            end
            ISSUE: begin
                if (commit) begin
                    loadPc    = 1'b1;
                    nextState = run ? FETCH : IDLE;
                end
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Next-PC arithmetic wraps naturally at 32 bits; jump outranks branch.
    assign pcPlus4      = pcReg + 32'd4;
    assign jumpTarget   = {pcPlus4[31:28], instrReg[25:0], 2'b00};
    assign branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
    assign branchTarget = pcPlus4 + branchOffset;

    always_comb begin
        pcNext = pcPlus4;
        if (jump) begin
            pcNext = jumpTarget;
        end else if (branch && zero) begin
            pcNext = branchTarget;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcReg    <= RESET_PC;
            instrReg <= 32'h0000_0000;
        end else begin
            if (loadPc) begin
                pcReg <= pcNext;
            end
            if (loadInstr) begin
                instrReg <= imem_rdata;
            end
        end
    end

    // Control outputs decode straight from state so reset clears them in the same cycle.
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);
    assign imem_addr   = pcReg;
    assign pc          = pcReg;
    assign instr       = instrReg;
    assign opcode      = instrReg[31:26];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table on one instance
// plus hand-written jump, halt-reset and mid-issue reset sequences.
module tb_fetch_sequencer;

    localparam logic [31:0] PC_A = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_B = 32'h3000_0000;
    localparam logic [31:0] BEQ_W  = 32'h1000_FFFE;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A: wraps from 0xFFFF_FFFC and carries most of the testing.
    logic        run, imemValid, commit, branch, jump, zero;
    logic [31:0] imemRdata;
    logic        imemReq, instrValid, halted;
    logic [31:0] imemAddr, instr, pc;
    logic [5:0]  opcode;

    // Instance B: starts at 0x3000_0000 for the jump-priority case.
    logic        bRun, bValid, bCommit, bBranch, bJump, bZero;
    logic [31:0] bRdata;
    logic        bReq, bIv, bHalted;
    logic [31:0] bAddr, bInstr, bPc;
    logic [5:0]  bOpcode;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(PC_A)) dutA (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(imemRdata), .imem_valid(imemValid),
        .instr(instr), .opcode(opcode), .instr_valid(instrValid),
        .commit(commit), .branch(branch), .jump(jump), .zero(zero),
        .pc(pc), .halted(halted)
    );

    fetch_sequencer #(.RESET_PC(PC_B)) dutB (
        .clk(clk), .rst_n(rst_n), .run(bRun),
        .imem_req(bReq), .imem_addr(bAddr), .imem_rdata(bRdata), .imem_valid(bValid),
        .instr(bInstr), .opcode(bOpcode), .instr_valid(bIv),
        .commit(bCommit), .branch(bBranch), .jump(bJump), .zero(bZero),
        .pc(bPc), .halted(bHalted)
    );

    typedef struct {
        logic        run;
        logic        valid;
        logic [31:0] rdata;
        logic        commit;
        logic        br;
        logic        jmp;
        logic        zr;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eIv;
        logic        eHalt;
        logic [31:0] eInstr;
    } vecT;

    vecT vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic vecT mk(input logic r, input logic v, input logic [31:0] d,
                               input logic c, input logic b, input logic j, input logic z,
                               input logic eReq, input logic [31:0] eAddr,
                               input logic eIv, input logic eHalt, input logic [31:0] eInstr);
        vecT t;
        t.run = r; t.valid = v; t.rdata = d; t.commit = c; t.br = b; t.jmp = j; t.zr = z;
        t.eReq = eReq; t.eAddr = eAddr; t.eIv = eIv; t.eHalt = eHalt; t.eInstr = eInstr;
        return t;
    endfunction

    function automatic logic [31:0] w(input int n);
        return 32'h0000_0100 + n;
    endfunction

    initial begin
        // Columns: run valid rdata commit br jmp zero | req addr instr_valid halted instr
        // (expected outputs are those visible during the cycle the inputs are driven)
        vecs.push_back(mk(1, 0, 0,      0, 0, 0, 0,  0, PC_A,  0, 0, 0));
        vecs.push_back(mk(1, 1, w(0),   0, 0, 0, 0,  1, PC_A,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0, 0,  0, PC_A,  1, 0, w(0)));
        vecs.push_back(mk(1, 1, w(1),   0, 0, 0, 0,  1, 32'h0, 0, 0, w(0)));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0, 0,  0, 32'h0, 1, 0, w(1)));
        vecs.push_back(mk(1, 1, w(2),   0, 0, 0, 0,  1, 32'h4, 0, 0, w(1)));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0, 0,  0, 32'h4, 1, 0, w(2)));
        vecs.push_back(mk(1, 1, w(3),   0, 0, 0, 0,  1, 32'h8, 0, 0, w(2)));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0, 0,  0, 32'h8, 1, 0, w(3)));
        vecs.push_back(mk(1, 1, w(4),   0, 0, 0, 0,  1, 32'hC, 0, 0, w(3)));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0, 0,  0, 32'hC, 1, 0, w(4)));
        // Taken branch at 0x10: 0x14 - 8 = 0x0C
        vecs.push_back(mk(1, 1, BEQ_W,  0, 0, 0, 0,  1, 32'h10, 0, 0, w(4)));
        vecs.push_back(mk(1, 0, 0,      1, 1, 0, 1,  0, 32'h10, 1, 0, BEQ_W));
        vecs.push_back(mk(1, 1, w(5),   0, 0, 0, 0,  1, 32'hC,  0, 0, BEQ_W));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0, 0,  0, 32'hC,  1, 0, w(5)));
        // Not-taken branch at 0x10 gives 0x14
        vecs.push_back(mk(1, 1, BEQ_W,  0, 0, 0, 0,  1, 32'h10, 0, 0, w(5)));
        vecs.push_back(mk(1, 0, 0,      1, 1, 0, 0,  0, 32'h10, 1, 0, BEQ_W));
        // Three wait states; a stray commit+jump during FETCH must be ignored
        vecs.push_back(mk(1, 0, 0,      0, 0, 0, 0,  1, 32'h14, 0, 0, BEQ_W));
        vecs.push_back(mk(1, 0, 0,      1, 0, 1, 0,  1, 32'h14, 0, 0, BEQ_W));
        vecs.push_back(mk(1, 0, 0,      0, 0, 0, 0,  1, 32'h14, 0, 0, BEQ_W));
        vecs.push_back(mk(1, 1, w(6),   0, 0, 0, 0,  1, 32'h14, 0, 0, BEQ_W));
        // Held in ISSUE; stray imem_valid must not overwrite instr; then commit with run low
        vecs.push_back(mk(1, 1, w(9),   0, 0, 0, 0,  0, 32'h14, 1, 0, w(6)));
        vecs.push_back(mk(0, 0, 0,      1, 0, 0, 0,  0, 32'h14, 1, 0, w(6)));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0,  0, 32'h18, 0, 0, w(6)));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0, 0,  0, 32'h18, 0, 0, w(6)));
        vecs.push_back(mk(1, 0, 0,      0, 0, 0, 0,  0, 32'h18, 0, 0, w(6)));
        // Halt word: sticky, no requests, commits ignored
        vecs.push_back(mk(1, 1, HALT_W, 0, 0, 0, 0,  1, 32'h18, 0, 0, w(6)));
        vecs.push_back(mk(1, 0, 0,      1, 0, 0, 0,  0, 32'h18, 0, 1, HALT_W));
        vecs.push_back(mk(1, 1, w(7),   1, 0, 1, 0,  0, 32'h18, 0, 1, HALT_W));
        vecs.push_back(mk(1, 0, 0,      0, 0, 0, 0,  0, 32'h18, 0, 1, HALT_W));

        rst_n = 1'b0;
        {run, imemValid, commit, branch, jump, zero} = '0;
        imemRdata = '0;
        {bRun, bValid, bCommit, bBranch, bJump, bZero} = '0;
        bRdata = '0;

        @(negedge clk);
        check("reset A pc", pc, PC_A);
        check("reset A req", {31'b0, imemReq}, 32'h0);
        check("reset B pc", bPc, PC_B);
        @(negedge clk);
        rst_n = 1'b1;

        // Jump priority on instance B
        bRun = 1'b1;
        @(negedge clk);
        check("B fetch req", {31'b0, bReq}, 32'h1);
        check("B fetch addr", bAddr, PC_B);
        bValid = 1'b1;
        bRdata = 32'h0800_0040;
        @(negedge clk);
        check("B issue valid", {31'b0, bIv}, 32'h1);
        check("B opcode", {26'b0, bOpcode}, 32'h2);
        bValid = 1'b0;
        bCommit = 1'b1; bJump = 1'b1; bBranch = 1'b1; bZero = 1'b1; bRun = 1'b0;
        @(negedge clk);
        {bCommit, bJump, bBranch, bZero} = '0;
        check("B jump pc", bPc, 32'h3000_0100);
        check("B idle req", {31'b0, bReq}, 32'h0);

        // Table-driven run on instance A
        for (int i = 0; i < vecs.size(); i++) begin
            run       = vecs[i].run;
            imemValid = vecs[i].valid;
            imemRdata = vecs[i].rdata;
            commit    = vecs[i].commit;
            branch    = vecs[i].br;
            jump      = vecs[i].jmp;
            zero      = vecs[i].zr;
            check($sformatf("v%0d req", i), {31'b0, imemReq}, {31'b0, vecs[i].eReq});
            check($sformatf("v%0d addr", i), imemAddr, vecs[i].eAddr);
            check($sformatf("v%0d pc", i), pc, vecs[i].eAddr);
            check($sformatf("v%0d instr_valid", i), {31'b0, instrValid}, {31'b0, vecs[i].eIv});
            check($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].eHalt});
            check($sformatf("v%0d instr", i), instr, vecs[i].eInstr);
            check($sformatf("v%0d opcode", i), {26'b0, opcode}, {26'b0, vecs[i].eInstr[31:26]});
            @(negedge clk);
        end
        {run, imemValid, commit, branch, jump, zero} = '0;

        // Asynchronous reset out of HALT
        #2 rst_n = 1'b0;
        #1;
        check("halt reset halted", {31'b0, halted}, 32'h0);
        check("halt reset pc", pc, PC_A);
        check("halt reset instr", instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Walk to pc=0x20 via a jump, then reset during ISSUE
        run = 1'b1;
        @(negedge clk);
        imemValid = 1'b1; imemRdata = 32'h0800_0008;
        @(negedge clk);
        imemValid = 1'b0; commit = 1'b1; jump = 1'b1;
        @(negedge clk);
        commit = 1'b0; jump = 1'b0;
        check("pre-reset fetch addr", imemAddr, 32'h20);
        imemValid = 1'b1; imemRdata = w(8);
        @(negedge clk);
        imemValid = 1'b0;
        check("pre-reset issue", {31'b0, instrValid}, 32'h1);
        check("pre-reset pc", pc, 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset pc", pc, PC_A);
        check("mid reset instr_valid", {31'b0, instrValid}, 32'h0);
        check("mid reset halted", {31'b0, halted}, 32'h0);
        check("mid reset req", {31'b0, imemReq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("resume req", {31'b0, imemReq}, 32'h1);
        check("resume addr", imemAddr, PC_A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
